tt_um_fjpolo_r2a03: RTL and testbench
=====================================

Name: tt_um_fjpolo_r2a03

Overview:
- Tiny Tapeout top-level slice of the Ricoh 2A03 audio unit.
- Two NES-style pulse (square) channels are programmed through a byte-wide write port on the TT pins.
- Each channel drives a 4-bit DAC nibble on uo_out.
- Sits directly under the TT harness; no other logic on chip.

Parameters:
- None. All constants live in the shared package.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset. Asynchronous, active-high: asserted when rst_n = 1. TT port name is kept; the polarity is decided and fixed.
- ena  in  1  design selected; register writes are ignored while 0.
- ui_in  in  8  write data.
- uio_in  in  8  [2:0] register address, [3] write strobe, [7:4] unused.
- uo_out  out  8  [3:0] pulse1 level, [7:4] pulse2 level.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all uio pins are inputs).

Behaviour:
- Reset (async assert, sync release to clk):
  - All registers, timers and sequencer steps = 0.
  - APU divider = 0, strobe history = 0.
  - uo_out = 0.
- Write detection: strobe is sampled every clk. A write occurs in the cycle where uio_in[3] = 1, the previous sample was 0, and ena = 1. Holding the strobe high produces exactly one write.
- Register map:
  - Addresses 0-3 select pulse1; 4-7 select pulse2. Offset = addr[1:0].
  - Offset 0: [7:6] duty, [3:0] volume; [5:4] stored and unused.
  - Offset 1: [0] channel enable; other bits stored and unused.
  - Offset 2: timer period[7:0].
  - Offset 3: [2:0] timer period[10:8]; the write also forces sequencer step to 0. The timer is not reloaded.
- APU tick: a 1-bit divider toggles every clk; a tick occurs in each cycle where the divider = 1, i.e. every 2 clk.
- Timer, per channel, on each tick:
  - If timer == 0: timer <= period and step <= step - 1 (mod 8).
  - Else: timer <= timer - 1.
  - Step dwell = 2*(period+1) clk; waveform period = 16*(period+1) clk.
- Duty table (step indices at which output is high):
  - duty0: {1}.
  - duty1: {1,2}.
  - duty2: {1,2,3,4}.
  - duty3: {0,3,4,5,6,7}.
- Channel output = volume only when all of: enable = 1, period >= 8, duty bit at current step = 1. Otherwise 0.
- uo_out is registered and reflects the channel state one clk after that state changes.
- Simultaneous events:
  - An offset-3 write in the same cycle as a step decrement: step = 0 wins.
  - Period writes take effect at the next timer reload.
  - Writes to one channel never disturb the other.
- Reset mid-waveform clears everything immediately (asynchronously). uo_out = 0 while reset is held.

Decomposition:
- Package r2a03_pkg:
  - Register offset constants.
  - 4x8 duty lookup constant.
  - Minimum-period constant (8).
- Sub-module r2a03_pulse_channel, instantiated twice. Contents:
  - Registers, timer, sequencer, mute logic.
  - Inputs: write enable, offset, data, tick.
  - Output: 4-bit level.
- The top level holds the divider, strobe edge detect, address decode and uo_out register.

Test Plan:
- Reset: hold rst_n = 1 for 5 clk, then release → uo_out = 0x00, uio_oe = 0x00, uio_out = 0x00, and uo_out stays 0 for 200 clk with no writes.
- Pulse1 50% duty:
  - Writes: addr0 = 0xBF (duty 2, vol 15), addr1 = 0x01, addr2 = 0x08, addr3 = 0x00.
  - → uo_out[3:0] steps between 0 and 15 with a 144-clk period.
  - High for 72 clk, starting 4 steps (72 clk) after the restart; uo_out[7:4] = 0 throughout.
- Muting, each case from the 50% setup:
  - Period 7 (addr2 = 0x07, addr3 = 0x00) → pulse1 output constant 0.
  - addr1 = 0x00 → output goes to 0.
  - Volume 0 → output 0.
- Write gating:
  - With ena = 0, a strobe edge leaves registers unchanged and output stays 0.
  - Strobe held high for 20 clk with changing ui_in → only the first-cycle data is written.
- Pulse2 duty 0: addr4 = 0x05, addr5 = 0x01, addr6 = 0x10, addr7 = 0x00 → uo_out[7:4] = 5 for 34 clk out of every 272, and pulse1 is unaffected.
- Reset mid-operation: assert rst_n during a high phase → uo_out = 0 immediately (asynchronously), and after release the output stays 0 until reprogrammed.

Source files
------------

// File: rtl/r2a03_pkg.sv
// Shared constants for the 2A03 pulse slice: register offsets, duty patterns
// and the minimum audible timer period.
package r2a03_pkg;

    typedef enum logic [1:0] {
        OFF_CTRL      = 2'd0,
        OFF_ENABLE    = 2'd1,
        OFF_PERIOD_LO = 2'd2,
        OFF_PERIOD_HI = 2'd3
    } reg_offset_e;

    // Row = duty setting, bit n = output high while the sequencer sits at step n.
    localparam logic [3:0][7:0] DUTY_TABLE = {8'hF9, 8'h1E, 8'h06, 8'h02};

    localparam logic [10:0] MIN_PERIOD = 11'd8;

    function automatic logic duty_high(input logic [1:0] duty, input logic [2:0] step);
        return DUTY_TABLE[duty][step];
    endfunction

endpackage

// File: rtl/r2a03_if.sv
// Write/level bus between the top-level decoder and one pulse channel.
interface r2a03_if;
    logic       wr_en;
    logic [2:0] addr;
    logic [7:0] data;
    logic       tick;
    logic [3:0] level;

    modport master (output wr_en, addr, data, tick, input level);
    modport slave  (input wr_en, addr, data, tick, output level);
endinterface

// File: rtl/r2a03_pulse_channel.sv
// One NES pulse channel: register file, 11-bit down-counting timer,
// 8-step duty sequencer and mute logic.
module r2a03_pulse_channel
    import r2a03_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    r2a03_if.slave bus
);

    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  enable_q, enable_d;
    logic [10:0] period_q, period_d;
    logic [10:0] timer_q, timer_d;
    logic [2:0]  step_q, step_d;

    logic unused_reg_bits;
    logic unused_addr_bit;
    assign unused_reg_bits = ^{ctrl_q[5:4], enable_q[7:1]};
    assign unused_addr_bit = bus.addr[2];

    // The offset-3 write is applied after the timer update so a restart wins
    // over a step decrement landing on the same cycle.
    always_comb begin
        ctrl_d   = ctrl_q;
        enable_d = enable_q;
        period_d = period_q;
        timer_d  = timer_q;
        step_d   = step_q;
        if (bus.tick) begin
            if (timer_q == 11'd0) begin
                timer_d = period_q;
                step_d  = step_q - 3'd1;
            end else begin
                timer_d = timer_q - 11'd1;
            end
        end
        if (bus.wr_en) begin
            case (reg_offset_e'(bus.addr[1:0]))
                OFF_CTRL:      ctrl_d = bus.data;
                OFF_ENABLE:    enable_d = bus.data;
                OFF_PERIOD_LO: period_d[7:0] = bus.data;
                OFF_PERIOD_HI: begin
                    period_d[10:8] = bus.data[2:0];
                    step_d         = 3'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= 8'd0;
            enable_q <= 8'd0;
            period_q <= 11'd0;
            timer_q  <= 11'd0;
            step_q   <= 3'd0;
        end else begin
            ctrl_q   <= ctrl_d;
            enable_q <= enable_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            step_q   <= step_d;
        end
    end

    assign bus.level = (enable_q[0] && (period_q >= MIN_PERIOD) && duty_high(ctrl_q[7:6], step_q))
                       ? ctrl_q[3:0] : 4'd0;

endmodule

// File: rtl/tt_um_fjpolo_r2a03.sv
// Tiny Tapeout top for two 2A03 pulse channels: write-strobe edge detect,
// APU tick divider, address decode and the registered DAC nibbles.
module tt_um_fjpolo_r2a03 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic       div_q, div_d;
    logic       strobe_q, strobe_d;
    logic [7:0] out_q, out_d;
    logic       write;

    logic unused_uio_bits;
    assign unused_uio_bits = ^uio_in[7:4];

    r2a03_if p1_bus ();
    r2a03_if p2_bus ();

    // rst_n is active-high on this die; the TT pin name is kept for the harness.
    always_comb begin
        div_d    = ~div_q;
        strobe_d = uio_in[3];
        write    = uio_in[3] & ~strobe_q & ena;
        out_d    = {p2_bus.level, p1_bus.level};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            div_q    <= 1'b0;
            strobe_q <= 1'b0;
            out_q    <= 8'd0;
        end else begin
            div_q    <= div_d;
            strobe_q <= strobe_d;
            out_q    <= out_d;
        end
    end

    assign p1_bus.wr_en = write & ~uio_in[2];
    assign p1_bus.addr  = uio_in[2:0];
    assign p1_bus.data  = ui_in;
    assign p1_bus.tick  = div_q;

    assign p2_bus.wr_en = write & uio_in[2];
    assign p2_bus.addr  = uio_in[2:0];
    assign p2_bus.data  = ui_in;
    assign p2_bus.tick  = div_q;

    r2a03_pulse_channel u_pulse1 (
        .clk (clk),
        .rst (rst_n),
        .bus (p1_bus.slave)
    );

    r2a03_pulse_channel u_pulse2 (
        .clk (clk),
        .rst (rst_n),
        .bus (p2_bus.slave)
    );

    assign uo_out  = out_q;
    assign uio_out = 8'd0;
    assign uio_oe  = 8'd0;

endmodule

// File: tb/tb_tt_um_fjpolo_r2a03.sv
// Directed bench for the 2A03 pulse slice: a table of channel setups with
// hand-derived high/low widths, plus sequences for gating, restart and reset.
module tb_tt_um_fjpolo_r2a03;

    localparam int WAIT_BOUND = 10000;

    typedef struct {
        string      name;
        logic [2:0] base;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] r3;
        int         level;
        int         hi;
        int         lo;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int pass_count;
    int check_count;

    r2a03_if bus ();

    assign ui_in     = bus.data;
    assign uio_in    = {4'h0, bus.wr_en, bus.addr};
    assign bus.level = uo_out[3:0];
    assign bus.tick  = 1'b0;

    tt_um_fjpolo_r2a03 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nib(input int ch);
        return (ch != 0) ? int'(uo_out[7:4]) : int'(bus.level);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        check_count++;
        if (actual >= lo && actual <= hi) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        bus.addr  = addr;
        bus.data  = data;
        bus.wr_en = 1'b1;
        @(negedge clk);
        bus.wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b1;
        bus.wr_en = 1'b0;
        ena = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic program4(input logic [2:0] base, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
        applyStimulus(base + 3'd0, r0);
        applyStimulus(base + 3'd1, r1);
        applyStimulus(base + 3'd2, r2);
        applyStimulus(base + 3'd3, r3);
    endtask

    // Largest nibble seen on either channel over a window.
    task automatic maxOver(input int cycles, output int maxv);
        maxv = 0;
        for (int i = 0; i < cycles; i++) begin
            if (nib(0) > maxv) maxv = nib(0);
            if (nib(1) > maxv) maxv = nib(1);
            @(negedge clk);
        end
    endtask

    task automatic waitHigh(input int ch, output int n);
        n = 0;
        while (nib(ch) == 0 && n < WAIT_BOUND) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Skip any partial high run, then measure one full high and low run.
    task automatic measureWave(input int ch, input bit check_other, output int found,
                               output int level, output int hi, output int lo, output int other_bad);
        int n;
        found = 0; level = 0; hi = 0; lo = 0; other_bad = 0; n = 0;
        while (nib(ch) != 0 && n < WAIT_BOUND) begin
            @(negedge clk);
            n++;
        end
        while (nib(ch) == 0 && n < WAIT_BOUND) begin
            if (check_other && nib(1 - ch) != 0) other_bad++;
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_BOUND) return;
        found = 1;
        level = nib(ch);
        while (nib(ch) != 0 && hi < WAIT_BOUND) begin
            if (nib(ch) != level) level = -1;
            if (check_other && nib(1 - ch) != 0) other_bad++;
            hi++;
            @(negedge clk);
        end
        while (nib(ch) == 0 && lo < WAIT_BOUND) begin
            if (check_other && nib(1 - ch) != 0) other_bad++;
            lo++;
            @(negedge clk);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int found, level, hi, lo, other_bad, maxv, n;

        pass_count  = 0;
        check_count = 0;
        rst_n     = 1'b1;
        ena       = 1'b1;
        bus.wr_en = 1'b0;
        bus.addr  = 3'd0;
        bus.data  = 8'd0;

        vecs[0] = '{"p1_duty2",   3'd0, 8'hBF, 8'h01, 8'h08, 8'h00, 15,   72,   72};
        vecs[1] = '{"p2_duty0",   3'd4, 8'h05, 8'h01, 8'h10, 8'h00,  5,   34,  238};
        vecs[2] = '{"p1_duty1",   3'd0, 8'h49, 8'h01, 8'h0A, 8'h00,  9,   44,  132};
        vecs[3] = '{"p2_duty3",   3'd4, 8'hCC, 8'h01, 8'h08, 8'h00, 12,  108,   36};
        vecs[4] = '{"p2_long",    3'd4, 8'hD7, 8'h01, 8'h00, 8'h01,  7, 3084, 1028};
        vecs[5] = '{"p1_period7", 3'd0, 8'hBF, 8'h01, 8'h07, 8'h00,  0,    0,    0};
        vecs[6] = '{"p1_disable", 3'd0, 8'hBF, 8'h00, 8'h08, 8'h00,  0,    0,    0};
        vecs[7] = '{"p1_vol0",    3'd0, 8'h80, 8'h01, 8'h08, 8'h00,  0,    0,    0};

        resetDut();
        checkOutput("reset_uo_out", int'(uo_out), 0);
        checkOutput("reset_uio_oe", int'(uio_oe), 0);
        checkOutput("reset_uio_out", int'(uio_out), 0);
        maxOver(200, maxv);
        checkOutput("reset_idle_200", maxv, 0);

        for (int v = 0; v < 8; v++) begin
            resetDut();
            program4(vecs[v].base, vecs[v].r0, vecs[v].r1, vecs[v].r2, vecs[v].r3);
            if (vecs[v].hi == 0) begin
                maxOver(300, maxv);
                checkOutput({vecs[v].name, "_muted"}, maxv, 0);
            end else begin
                measureWave(int'(vecs[v].base[2]), 1'b1, found, level, hi, lo, other_bad);
                checkOutput({vecs[v].name, "_found"}, found, 1);
                checkOutput({vecs[v].name, "_level"}, level, vecs[v].level);
                checkOutput({vecs[v].name, "_high"}, hi, vecs[v].hi);
                checkOutput({vecs[v].name, "_low"}, lo, vecs[v].lo);
                checkOutput({vecs[v].name, "_other"}, other_bad, 0);
            end
        end

        $display("[TB] write gating with ena low");
        resetDut();
        ena = 1'b0;
        program4(3'd0, 8'hBF, 8'h01, 8'h08, 8'h00);
        ena = 1'b1;
        maxOver(300, maxv);
        checkOutput("ena0_no_write", maxv, 0);
        program4(3'd0, 8'hBF, 8'h01, 8'h08, 8'h00);
        ena = 1'b0;
        applyStimulus(3'd0, 8'h80);
        ena = 1'b1;
        measureWave(0, 1'b1, found, level, hi, lo, other_bad);
        checkOutput("ena0_keep_level", level, 15);
        checkOutput("ena0_keep_high", hi, 72);

        $display("[TB] strobe held high");
        resetDut();
        applyStimulus(3'd1, 8'h01);
        applyStimulus(3'd2, 8'h08);
        applyStimulus(3'd3, 8'h00);
        @(negedge clk);
        bus.addr  = 3'd0;
        bus.data  = 8'hBF;
        bus.wr_en = 1'b1;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            bus.data = 8'(i);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        measureWave(0, 1'b1, found, level, hi, lo, other_bad);
        checkOutput("held_strobe_level", level, 15);
        checkOutput("held_strobe_high", hi, 72);

        $display("[TB] sequencer restart while high");
        resetDut();
        program4(3'd0, 8'hBF, 8'h01, 8'h08, 8'h00);
        waitHigh(0, n);
        repeat (10) @(negedge clk);
        applyStimulus(3'd3, 8'h00);
        checkOutput("restart_low", nib(0), 0);
        waitHigh(0, n);
        checkRange("restart_rise_delay", n, 50, 76);

        $display("[TB] both channels together");
        resetDut();
        program4(3'd0, 8'hBF, 8'h01, 8'h08, 8'h00);
        program4(3'd4, 8'h05, 8'h01, 8'h10, 8'h00);
        measureWave(0, 1'b0, found, level, hi, lo, other_bad);
        checkOutput("both_p1_level", level, 15);
        checkOutput("both_p1_high", hi, 72);
        checkOutput("both_p1_low", lo, 72);
        measureWave(1, 1'b0, found, level, hi, lo, other_bad);
        checkOutput("both_p2_level", level, 5);
        checkOutput("both_p2_high", hi, 34);
        checkOutput("both_p2_low", lo, 238);

        $display("[TB] reset mid-waveform");
        resetDut();
        program4(3'd0, 8'hBF, 8'h01, 8'h08, 8'h00);
        waitHigh(0, n);
        checkOutput("midreset_was_high", nib(0), 15);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 checkOutput("midreset_async_clear", int'(uo_out), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        maxOver(300, maxv);
        checkOutput("midreset_stays_zero", maxv, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
